dmem_port_arbiter: RTL

//   Shares the single data_memory port between two requesters: port 0 (processor

---
 rtl/dmem_port_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares the single data_memory port between the processor
//            load/store path (port 0) and the boot loader / debug DMA (port 1).
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_in,
  input  logic [1:0]  we_in,
  input  logic [3:0]  size_in,
  input  logic [63:0] addr_in,
  input  logic [63:0] wdata_in,
  output logic [1:0]  gnt_out,
  output logic [1:0]  done_out,
  output logic [31:0] rdata_out,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata_out,
  output logic [1:0]  mem_size_out,
  output logic        mem_re_out,
  output logic        mem_we_out,
  input  logic [31:0] mem_rdata_in
);

  localparam logic [2:0] c_lat_init = 3'(RD_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        w_capture;
  logic        w_load;
  logic        w_win;

  logic        r_sel;
  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_last_gnt;

  // Tie-break: fixed priority to port 0, or the port that did not go last.
  always_comb begin
    w_win = 1'b0;
    case (req_in)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = PRIO_FIXED ? 1'b0 : ~r_last_gnt;
      default: w_win = 1'b0;
    endcase
  end

  assign w_load = (r_state == ST_IDLE) && (|req_in);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req_in) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_we) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = c_lat_init;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 3'd1;
        // A zero-latency misconfiguration still terminates on the first pass.
        if (r_cnt <= 3'd1) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sel      <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_rdata    <= 32'h0;
      r_last_gnt <= 1'b1;
    end else begin
      if (w_load) begin
        r_sel   <= w_win;
        r_we    <= w_win ? we_in[1]         : we_in[0];
        r_size  <= w_win ? size_in[3:2]     : size_in[1:0];
        r_addr  <= w_win ? addr_in[63:32]   : addr_in[31:0];
        r_wdata <= w_win ? wdata_in[63:32]  : wdata_in[31:0];
      end
      if (w_capture) begin
        r_rdata <= mem_rdata_in;
      end
      if (r_state == ST_RESP) begin
        r_last_gnt <= r_sel;
      end
    end
  end

  assign gnt_out       = (r_state != ST_IDLE) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  assign done_out      = (r_state == ST_RESP) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
  assign mem_re_out    = (r_state == ST_ISSUE) && !r_we;
  assign mem_we_out    = (r_state == ST_ISSUE) &&  r_we;
  assign mem_addr_out  = r_addr;
  assign mem_wdata_out = r_wdata;
  assign mem_size_out  = r_size;
  assign rdata_out     = r_rdata;

endmodule
`default_nettype wire
